// File: rtl/hex_reader_to_binary_pkg.sv
// Shared types for the 7-segment readback path: segment enum, FSM states,
// BCD correction constant and the segment-to-digit lookup.
package hex_reader_to_binary_pkg;

   typedef enum logic [6:0] {
      zero  = 7'h3F,
      one   = 7'h06,
      two   = 7'h5B,
      three = 7'h4F,
      four  = 7'h66,
      five  = 7'h6D,
      six   = 7'h7D,
      seven = 7'h07,
      eight = 7'h7F,
      nine  = 7'h6F
   } dec_num_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_DONE    = 2'd3
   } fsm_state_e;

   localparam logic [3:0] BCD_ADJUST = 4'd3;

   // Returns {valid, digit}; any pattern outside zero..nine decodes as invalid.
   function automatic logic [4:0] dec_num_to_digit(input dec_num_e seg);
      case (seg)
         zero:    return {1'b1, 4'd0};
         one:     return {1'b1, 4'd1};
         two:     return {1'b1, 4'd2};
         three:   return {1'b1, 4'd3};
         four:    return {1'b1, 4'd4};
         five:    return {1'b1, 4'd5};
         six:     return {1'b1, 4'd6};
         seven:   return {1'b1, 4'd7};
         eight:   return {1'b1, 4'd8};
         nine:    return {1'b1, 4'd9};
         default: return {1'b0, 4'd0};
      endcase
   endfunction

endpackage

// File: rtl/hex_reader_to_binary_seg_decoder.sv
// Combinational decode of one 7-segment pattern into a BCD digit plus valid.
module hex_seg_decoder
   import hex_reader_to_binary_pkg::*;
(
   input  dec_num_e   seg,
   output logic [3:0] digit,
   output logic       valid
);

   logic [4:0] dec_s;

   assign dec_s = dec_num_to_digit(seg);
   assign valid = dec_s[4];
   assign digit = dec_s[3:0];

endmodule

// File: rtl/hex_reader_to_binary.sv
// Reads six 7-segment patterns back into binary: decode to BCD, then a
// sequential reverse double-dabble (shift right, subtract 3 on nibbles >= 8).
module hex_reader_to_binary
   import hex_reader_to_binary_pkg::*;
#(
   parameter int DECIMAL_DIGITS = 6,
   parameter int OUTPUT_WIDTH   = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  dec_num_e                HEX0,
   input  dec_num_e                HEX1,
   input  dec_num_e                HEX2,
   input  dec_num_e                HEX3,
   input  dec_num_e                HEX4,
   input  dec_num_e                HEX5,
   input  logic                    start,
   output logic                    busy,
   output logic [OUTPUT_WIDTH-1:0] o_binary,
   output logic                    o_dv,
   output logic                    o_error
);

   localparam int BCD_W = 4 * DECIMAL_DIGITS;
   localparam int SR_W  = BCD_W + OUTPUT_WIDTH;
   localparam int CNT_W = $clog2(OUTPUT_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OUTPUT_WIDTH - 1);

   fsm_state_e                state_r;
   dec_num_e                  hex_in_s [6];
   dec_num_e                  hex_r    [DECIMAL_DIGITS];
   logic [BCD_W-1:0]          bcd_s;
   logic [DECIMAL_DIGITS-1:0] valid_s;
   logic [SR_W-1:0]           sr_r;
   logic [SR_W-1:0]           next_sr_s;
   logic [CNT_W-1:0]          cnt_r;
   logic                      err_r;

   assign hex_in_s[0] = HEX0;
   assign hex_in_s[1] = HEX1;
   assign hex_in_s[2] = HEX2;
   assign hex_in_s[3] = HEX3;
   assign hex_in_s[4] = HEX4;
   assign hex_in_s[5] = HEX5;

   for (genvar i = 0; i < DECIMAL_DIGITS; i++) begin : g_dec
      hex_seg_decoder u_dec (
         .seg   (hex_r[i]),
         .digit (bcd_s[4*i +: 4]),
         .valid (valid_s[i])
      );
   end

   // One reverse double-dabble iteration: shift right, then correct each BCD nibble.
   always_comb begin
      logic [3:0] nib;
      nib       = 4'd0;
      next_sr_s = sr_r >> 1;
      for (int k = 0; k < DECIMAL_DIGITS; k++) begin
         nib = next_sr_s[OUTPUT_WIDTH + 4*k +: 4];
         next_sr_s[OUTPUT_WIDTH + 4*k +: 4] = (nib >= 4'd8) ? (nib - BCD_ADJUST) : nib;
      end
   end

   // Conversion FSM; result and o_dv are loaded on the edge entering DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         busy     <= 1'b0;
         o_dv     <= 1'b0;
         o_error  <= 1'b0;
         o_binary <= '0;
         sr_r     <= '0;
         cnt_r    <= '0;
         err_r    <= 1'b0;
         for (int i = 0; i < DECIMAL_DIGITS; i++) hex_r[i] <= zero;
      end else begin
         o_dv <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < DECIMAL_DIGITS; i++) hex_r[i] <= hex_in_s[i];
                  busy    <= 1'b1;
                  state_r <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (&valid_s) begin
                  sr_r    <= {bcd_s, {OUTPUT_WIDTH{1'b0}}};
                  cnt_r   <= '0;
                  err_r   <= 1'b0;
                  state_r <= ST_SHIFT;
               end else begin
                  err_r    <= 1'b1;
                  o_binary <= '0;
                  o_error  <= 1'b1;
                  o_dv     <= 1'b1;
                  state_r  <= ST_DONE;
               end
            end
            ST_SHIFT: begin
               sr_r  <= next_sr_s;
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == LAST_ITER) begin
                  o_binary <= err_r ? '0 : next_sr_s[OUTPUT_WIDTH-1:0];
                  o_error  <= err_r;
                  o_dv     <= 1'b1;
                  state_r  <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_reader_to_binary.sv
// Directed scoreboard bench for hex_reader_to_binary: expected results are
// queued when a start is driven and checked when o_dv pulses.
module tb_hex_reader_to_binary;
   import hex_reader_to_binary_pkg::*;

   localparam int OW = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   dec_num_e      hex_tb [6];
   dec_num_e      seg_tab [10];
   logic          busy;
   logic          o_dv;
   logic          o_error;
   logic [OW-1:0] o_binary;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_busy_low = 1'b0;

   typedef struct {
      logic [OW-1:0] bin;
      logic          err;
      int            at;
   } exp_t;
   exp_t sb[$];

   hex_reader_to_binary dut (
      .clk      (clk),
      .reset    (reset),
      .HEX0     (hex_tb[0]),
      .HEX1     (hex_tb[1]),
      .HEX2     (hex_tb[2]),
      .HEX3     (hex_tb[3]),
      .HEX4     (hex_tb[4]),
      .HEX5     (hex_tb[5]),
      .start    (start),
      .busy     (busy),
      .o_binary (o_binary),
      .o_dv     (o_dv),
      .o_error  (o_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_hex(input int value, input int bad_pos);
      int v;
      v = value;
      for (int i = 0; i < 6; i++) begin
         hex_tb[i] = seg_tab[v % 10];
         v = v / 10;
      end
      if (bad_pos >= 0) hex_tb[bad_pos] = dec_num_e'(7'h00);
   endtask

   task automatic push_exp(input int value, input bit bad);
      exp_t e;
      e.bin = bad ? '0 : OW'(value);
      e.err = bad;
      e.at  = cyc + (bad ? 2 : OW + 2);
      sb.push_back(e);
   endtask

   // Drives a one-cycle start pulse at a falling edge; returns one cycle later.
   task automatic start_conv(input int value, input int bad_pos);
      @(negedge clk);
      set_hex(value, bad_pos);
      start = 1'b1;
      push_exp(value, bad_pos >= 0);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("completion_timeout", 32'(n < 200), 32'd1);
      @(negedge clk);
   endtask

   // Output monitor: pops the scoreboard on every o_dv and checks timing.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && chk_busy_low) check("busy_after_dv", 32'(busy), 32'd0);
         chk_busy_low = 1'b0;
         if (reset && o_dv) begin
            check("spurious_dv", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("o_binary", 32'(o_binary), 32'(e.bin));
               check("o_error", 32'(o_error), 32'(e.err));
               check("dv_cycle", 32'(cyc), 32'(e.at));
               check("busy_during_dv", 32'(busy), 32'd1);
            end
            chk_busy_low = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      seg_tab = '{zero, one, two, three, four, five, six, seven, eight, nine};
      set_hex(0, -1);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dv", 32'(o_dv), 32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_binary", 32'(o_binary), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      start_conv(123456, -1);
      wait_done();
      start_conv(999999, -1);
      wait_done();
      start_conv(0, -1);
      wait_done();

      // Illegal digit, then result held, then cleared by a valid conversion.
      start_conv(123456, 3);
      wait_done();
      repeat (3) @(negedge clk);
      check("err_held", 32'(o_error), 32'd1);
      check("err_bin_held", 32'(o_binary), 32'd0);
      start_conv(654321, -1);
      wait_done();

      // Extra starts and input changes during busy are ignored.
      start_conv(42, -1);
      repeat (2) @(negedge clk);
      set_hex(999999, -1);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset in the middle of SHIFT aborts the run.
      start_conv(555555, -1);
      repeat (11) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_dv", 32'(o_dv), 32'd0);
      check("abort_binary", 32'(o_binary), 32'd0);
      check("abort_error", 32'(o_error), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      start_conv(100, -1);
      wait_done();

      // Continuous start: one conversion every 23 cycles.
      @(negedge clk);
      set_hex(7, -1);
      start = 1'b1;
      push_exp(7, 1'b0);
      sb[0].at = cyc + OW + 2;
      push_exp(7, 1'b0);
      sb[1].at = cyc + OW + 2 + 23;
      push_exp(7, 1'b0);
      sb[2].at = cyc + OW + 2 + 46;
      repeat (50) @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (30) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
